// File: rtl/sound_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the sound-engine arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sound_arbiter_pkg;

    localparam int OCTAVE_BITS = 3;
    localparam int NOTE_BITS   = 4;
    localparam int LENGTH_BITS = 3;

    // Requester indices, in descending priority order.
    localparam int SRC_LIVE = 0;
    localparam int SRC_REC  = 1;
    localparam int SRC_SONG = 2;
    localparam int NUM_SRC  = 3;

    localparam logic [NUM_SRC-1:0] LIVE_ONEHOT  = 3'b001;
    localparam logic [15:0]        NOTE_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == NOTE_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sound_arbiter_prio_pick3.sv
// Fixed-priority picker: bit 0 wins, then bit 1, then bit 2; one-hot plus index.
// Latency: combinational.
// Backpressure: none; pure function of req.
// Ports: req in [2:0]; pick out one-hot [2:0]; idx out [1:0]; any out (some req high).
module prio_pick3
    import sound_arbiter_pkg::*;
(
    input  logic [2:0] req,
    output logic [2:0] pick,
    output logic [1:0] idx,
    output logic       any
);

    always_comb begin
        pick = 3'b000;
        idx  = 2'd0;
        if (req[SRC_LIVE]) begin
            pick = 3'b001;
            idx  = 2'(SRC_LIVE);
        end else if (req[SRC_REC]) begin
            pick = 3'b010;
            idx  = 2'(SRC_REC);
        end else if (req[SRC_SONG]) begin
            pick = 3'b100;
            idx  = 2'(SRC_SONG);
        end
    end

    assign any = |req;

endmodule

// File: rtl/sound_arbiter.sv
// Shares one Sound engine between live hits, record playback and song autoplay.
// Latency: req sampled at edge N -> grant/snd_en/payload visible after edge N.
// Backpressure: requesters hold req+payload until done/abort; arbitration only in IDLE.
// Ports: clk, rst (async, high); en; req[2:0] with packed oct/note/len payloads;
//        grant/done/abort[2:0]; snd_en + latched snd_oct/snd_note/snd_len; snd_over
//        from engine; busy; note_cnt (saturating completed notes); timeout_err (sticky).
module sound_arbiter
    import sound_arbiter_pkg::*;
#(
    parameter int OCT_W         = OCTAVE_BITS,
    parameter int NOTE_W        = NOTE_BITS,
    parameter int LEN_W         = LENGTH_BITS,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 1024,
    parameter bit PREEMPT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            req,
    input  logic [3*OCT_W-1:0]    oct_in,
    input  logic [3*NOTE_W-1:0]   note_in,
    input  logic [3*LEN_W-1:0]    len_in,
    output logic [2:0]            grant,
    output logic [2:0]            done,
    output logic [2:0]            abort,
    output logic                  snd_en,
    output logic [OCT_W-1:0]      snd_oct,
    output logic [NOTE_W-1:0]     snd_note,
    output logic [LEN_W-1:0]      snd_len,
    input  logic                  snd_over,
    output logic                  busy,
    output logic [15:0]           note_cnt,
    output logic                  timeout_err
);

    localparam int WAIT_W = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    state_t              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [2:0]          done_q, done_d;
    logic [2:0]          abort_q, abort_d;
    logic                snd_en_q, snd_en_d;
    logic [OCT_W-1:0]    snd_oct_q, snd_oct_d;
    logic [NOTE_W-1:0]   snd_note_q, snd_note_d;
    logic [LEN_W-1:0]    snd_len_q, snd_len_d;
    logic [15:0]         note_cnt_q, note_cnt_d;
    logic                timeout_err_q, timeout_err_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    // Set for the single cycle after a preemption, while snd_en is held low
    // so the engine restarts; snd_over is stale from the aborted note then.
    logic                hold_q, hold_d;

    logic [2:0]          pick;
    logic [1:0]          pick_idx;
    logic                pick_any;
    logic [OCT_W-1:0]    win_oct;
    logic [NOTE_W-1:0]   win_note;
    logic [LEN_W-1:0]    win_len;
    logic                preempt_hit;

    prio_pick3 u_pick (
        .req  (req),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        win_oct  = '0;
        win_note = '0;
        win_len  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick_idx == 2'(i)) begin
                win_oct  = oct_in[i*OCT_W +: OCT_W];
                win_note = note_in[i*NOTE_W +: NOTE_W];
                win_len  = len_in[i*LEN_W +: LEN_W];
            end
        end
    end

    // A live hit may take the engine from record or song, never from another live note.
    assign preempt_hit = PREEMPT && req[SRC_LIVE] && !grant_q[SRC_LIVE];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        done_d        = '0;
        abort_d       = '0;
        snd_en_d      = snd_en_q;
        snd_oct_d     = snd_oct_q;
        snd_note_d    = snd_note_q;
        snd_len_d     = snd_len_q;
        note_cnt_d    = note_cnt_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        hold_d        = 1'b0;

        if (!en) begin
            // grant_q is nonzero only while a note is owned, so this is the abort pulse.
            abort_d    = grant_q;
            state_d    = ST_IDLE;
            grant_d    = '0;
            snd_en_d   = 1'b0;
            snd_oct_d  = '0;
            snd_note_d = '0;
            snd_len_d  = '0;
            note_cnt_d = '0;
            wait_cnt_d = '0;
            gap_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_d    = ST_START;
                        grant_d    = pick;
                        snd_en_d   = 1'b1;
                        snd_oct_d  = win_oct;
                        snd_note_d = win_note;
                        snd_len_d  = win_len;
                        wait_cnt_d = '0;
                    end
                end
                ST_START, ST_PLAY: begin
                    if (state_q == ST_PLAY && snd_over) begin
                        // Completion wins over a simultaneous preemption.
                        done_d     = grant_q;
                        note_cnt_d = sat_inc16(note_cnt_q);
                        state_d    = ST_GAP;
                        grant_d    = '0;
                        snd_en_d   = 1'b0;
                        gap_cnt_d  = '0;
                    end else if (preempt_hit) begin
                        abort_d    = grant_q;
                        grant_d    = LIVE_ONEHOT;
                        snd_en_d   = 1'b0;
                        snd_oct_d  = oct_in[SRC_LIVE*OCT_W +: OCT_W];
                        snd_note_d = note_in[SRC_LIVE*NOTE_W +: NOTE_W];
                        snd_len_d  = len_in[SRC_LIVE*LEN_W +: LEN_W];
                        state_d    = ST_START;
                        wait_cnt_d = '0;
                        hold_d     = 1'b1;
                    end else if (state_q == ST_START) begin
                        if (hold_q) begin
                            snd_en_d = 1'b1;
                        end else if (!snd_over) begin
                            state_d = ST_PLAY;
                        end else if (wait_cnt_q == WAIT_LAST) begin
                            abort_d       = grant_q;
                            timeout_err_d = 1'b1;
                            state_d       = ST_GAP;
                            grant_d       = '0;
                            snd_en_d      = 1'b0;
                            gap_cnt_d     = '0;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            done_q        <= '0;
            abort_q       <= '0;
            snd_en_q      <= 1'b0;
            snd_oct_q     <= '0;
            snd_note_q    <= '0;
            snd_len_q     <= '0;
            note_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            hold_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            abort_q       <= abort_d;
            snd_en_q      <= snd_en_d;
            snd_oct_q     <= snd_oct_d;
            snd_note_q    <= snd_note_d;
            snd_len_q     <= snd_len_d;
            note_cnt_q    <= note_cnt_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            hold_q        <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign abort       = abort_q;
    assign snd_en      = snd_en_q;
    assign snd_oct     = snd_oct_q;
    assign snd_note    = snd_note_q;
    assign snd_len     = snd_len_q;
    assign note_cnt    = note_cnt_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter: directed scenarios plus randomized service-order checks.
// Two instances: dut (preemption on) and dut_b (preemption off), each with an engine model.
module tb_sound_arbiter;

    localparam int OW  = 3;
    localparam int NW  = 4;
    localparam int LW  = 3;
    localparam int GAP = 16;
    localparam int TMO = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [2:0]      req = '0, req_b = '0;
    logic [3*OW-1:0] oct_in = '0, oct_b = '0;
    logic [3*NW-1:0] note_in = '0, note_b = '0;
    logic [3*LW-1:0] len_in = '0, len_b = '0;

    logic [2:0]    grant, done, abort, grant_b, done_b, abort_b;
    logic          snd_en, snd_en_b, busy, busy_b, timeout_err, timeout_err_b;
    logic [OW-1:0] snd_oct, snd_oct_b;
    logic [NW-1:0] snd_note, snd_note_b;
    logic [LW-1:0] snd_len, snd_len_b;
    logic [15:0]   note_cnt, note_cnt_b;
    logic          snd_over = 1'b1, snd_over_b = 1'b1;

    int eng_cnt = 0, eng_cnt_b = 0;
    int play_len = 20;
    bit stuck = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sound_arbiter #(.GAP_CYCLES(GAP), .START_TIMEOUT(TMO), .PREEMPT(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .oct_in(oct_in), .note_in(note_in), .len_in(len_in),
        .grant(grant), .done(done), .abort(abort),
        .snd_en(snd_en), .snd_oct(snd_oct), .snd_note(snd_note), .snd_len(snd_len),
        .snd_over(snd_over), .busy(busy), .note_cnt(note_cnt), .timeout_err(timeout_err)
    );

    sound_arbiter #(.GAP_CYCLES(GAP), .START_TIMEOUT(TMO), .PREEMPT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req_b),
        .oct_in(oct_b), .note_in(note_b), .len_in(len_b),
        .grant(grant_b), .done(done_b), .abort(abort_b),
        .snd_en(snd_en_b), .snd_oct(snd_oct_b), .snd_note(snd_note_b), .snd_len(snd_len_b),
        .snd_over(snd_over_b), .busy(busy_b), .note_cnt(note_cnt_b), .timeout_err(timeout_err_b)
    );

    // Engine model: over drops 2 cycles after enable, rises play_len cycles later.
    always @(posedge clk) begin
        if (!snd_en) begin
            eng_cnt  <= 0;
            snd_over <= 1'b1;
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (stuck)                        snd_over <= 1'b1;
            else if (eng_cnt == 1)            snd_over <= 1'b0;
            else if (eng_cnt == 1 + play_len) snd_over <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!snd_en_b) begin
            eng_cnt_b  <= 0;
            snd_over_b <= 1'b1;
        end else begin
            eng_cnt_b <= eng_cnt_b + 1;
            if (eng_cnt_b == 1)                 snd_over_b <= 1'b0;
            else if (eng_cnt_b == 1 + play_len) snd_over_b <= 1'b1;
        end
    end

    task automatic set_pl(input int src, input logic [OW-1:0] o, input logic [NW-1:0] n, input logic [LW-1:0] l);
        oct_in[src*OW +: OW]  = o;
        note_in[src*NW +: NW] = n;
        len_in[src*LW +: LW]  = l;
    endtask

    task automatic set_pl_b(input int src, input logic [OW-1:0] o, input logic [NW-1:0] n, input logic [LW-1:0] l);
        oct_b[src*OW +: OW]  = o;
        note_b[src*NW +: NW] = n;
        len_b[src*LW +: LW]  = l;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = '0; req_b = '0;
        repeat (3) @(negedge clk);
        checks++; if ({grant, done, abort, snd_en, busy} !== 11'b0) begin errors++; $display("FAIL reset_ctrl: got %b required 0", {grant, done, abort, snd_en, busy}); end
        checks++; if ({snd_oct, snd_note, snd_len} !== 10'b0) begin errors++; $display("FAIL reset_payload: got %h required 0", {snd_oct, snd_note, snd_len}); end
        checks++; if ({note_cnt, timeout_err} !== 17'b0) begin errors++; $display("FAIL reset_cnt: got %h required 0", {note_cnt, timeout_err}); end
        checks++; if ({grant_b, snd_en_b, busy_b} !== 5'b0) begin errors++; $display("FAIL reset_b: got %b required 0", {grant_b, snd_en_b, busy_b}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy got %b required 0", busy); end
    endtask

    task automatic test_single_song();
        int n, en_hi, extra;
        play_len = 20;
        set_pl(2, 3'd4, 4'd5, 3'd2);
        req = 3'b100;
        @(negedge clk);
        checks++; if ({grant, snd_en} !== 4'b1001) begin errors++; $display("FAIL song_grant: got %b required 1001", {grant, snd_en}); end
        checks++; if ({snd_oct, snd_note, snd_len} !== {3'd4, 4'd5, 3'd2}) begin errors++; $display("FAIL song_payload: got %h required %h", {snd_oct, snd_note, snd_len}, {3'd4, 4'd5, 3'd2}); end
        n = 0; while (done == 3'b000 && n < 200) begin @(negedge clk); n++; end
        checks++; if (done !== 3'b100) begin errors++; $display("FAIL song_done: got %b required 100", done); end
        req = 3'b000;
        n = 0; en_hi = 0; extra = 0;
        while (busy && n < 100) begin
            if (snd_en) en_hi++;
            @(negedge clk); n++;
            if (done != 3'b000) extra++;
        end
        checks++; if (n !== GAP) begin errors++; $display("FAIL song_gap_len: got %0d required %0d", n, GAP); end
        checks++; if (en_hi !== 0 || extra !== 0) begin errors++; $display("FAIL song_gap_quiet: snd_en high %0d, extra done %0d, required 0/0", en_hi, extra); end
        checks++; if (note_cnt !== 16'd1) begin errors++; $display("FAIL song_cnt: got %0d required 1", note_cnt); end
    endtask

    task automatic test_priority();
        int n;
        set_pl(1, 3'd2, 4'd3, 3'd1);
        set_pl(2, 3'd4, 4'd9, 3'd3);
        req = 3'b110;
        @(negedge clk);
        checks++; if (grant !== 3'b010 || snd_note !== 4'd3) begin errors++; $display("FAIL prio_first: grant %b note %0d required 010 note 3", grant, snd_note); end
        n = 0; while (done == 3'b000 && n < 200) begin @(negedge clk); n++; end
        checks++; if (done !== 3'b010) begin errors++; $display("FAIL prio_rec_done: got %b required 010", done); end
        req = 3'b100;
        n = 0;
        do begin @(negedge clk); n++; end while (grant == 3'b000 && n < 100);
        checks++; if (n !== GAP + 1) begin errors++; $display("FAIL prio_gap: got %0d required %0d", n, GAP + 1); end
        checks++; if (grant !== 3'b100 || snd_note !== 4'd9) begin errors++; $display("FAIL prio_second: grant %b note %0d required 100 note 9", grant, snd_note); end
        n = 0; while (done == 3'b000 && n < 200) begin @(negedge clk); n++; end
        checks++; if (done !== 3'b100 || note_cnt !== 16'd3) begin errors++; $display("FAIL prio_song_done: done %b cnt %0d required 100 cnt 3", done, note_cnt); end
        req = 3'b000;
        n = 0; while (busy && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic test_preempt();
        int n;
        set_pl(2, 3'd1, 4'd2, 3'd3);
        set_pl(0, 3'd6, 4'd7, 3'd4);
        req = 3'b100;
        repeat (6) @(negedge clk);
        req = 3'b101;
        @(negedge clk);
        checks++; if (abort !== 3'b100 || done !== 3'b000) begin errors++; $display("FAIL pre_abort: abort %b done %b required 100/000", abort, done); end
        checks++; if ({grant, snd_en, busy} !== 5'b00101 || snd_note !== 4'd7) begin errors++; $display("FAIL pre_switch: grant/en/busy %b note %0d required 00101 note 7", {grant, snd_en, busy}, snd_note); end
        req = 3'b001;
        @(negedge clk);
        checks++; if ({grant, snd_en, abort} !== 7'b0011000) begin errors++; $display("FAIL pre_resume: got %b required 0011000", {grant, snd_en, abort}); end
        n = 0; while (done == 3'b000 && n < 200) begin @(negedge clk); n++; end
        checks++; if (done !== 3'b001 || note_cnt !== 16'd4) begin errors++; $display("FAIL pre_live_done: done %b cnt %0d required 001 cnt 4", done, note_cnt); end
        req = 3'b000;
        n = 0; while (busy && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic test_no_preempt();
        int n, bad;
        set_pl_b(2, 3'd1, 4'd2, 3'd3);
        set_pl_b(0, 3'd6, 4'd7, 3'd4);
        req_b = 3'b100;
        repeat (6) @(negedge clk);
        req_b = 3'b101;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (grant_b !== 3'b100 || abort_b !== 3'b000 || snd_en_b !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL nopre_hold: %0d bad cycles required 0", bad); end
        n = 0; while (done_b == 3'b000 && n < 200) begin @(negedge clk); n++; end
        checks++; if (done_b !== 3'b100) begin errors++; $display("FAIL nopre_song_done: got %b required 100", done_b); end
        req_b = 3'b001;
        n = 0;
        do begin @(negedge clk); n++; end while (grant_b == 3'b000 && n < 100);
        checks++; if (n !== GAP + 1 || grant_b !== 3'b001 || snd_note_b !== 4'd7) begin errors++; $display("FAIL nopre_live: wait %0d grant %b note %0d required %0d/001/7", n, grant_b, snd_note_b, GAP + 1); end
        n = 0; while (done_b == 3'b000 && n < 200) begin @(negedge clk); n++; end
        req_b = 3'b000;
        n = 0; while (busy_b && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic test_timeout();
        int n;
        stuck = 1'b1;
        set_pl(1, 3'd3, 4'd11, 3'd5);
        req = 3'b010;
        n = 0; while (grant == 3'b000 && n < 50) begin @(negedge clk); n++; end
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL tmo_grant: got %b required 010", grant); end
        n = 0; while (abort == 3'b000 && n < 1200) begin @(negedge clk); n++; end
        checks++; if (n !== TMO || abort !== 3'b010) begin errors++; $display("FAIL tmo_abort: after %0d abort %b required %0d/010", n, abort, TMO); end
        checks++; if (timeout_err !== 1'b1 || done !== 3'b000) begin errors++; $display("FAIL tmo_flag: err %b done %b required 1/000", timeout_err, done); end
        req = 3'b000; stuck = 1'b0;
        n = 0; while (busy && n < 100) begin @(negedge clk); n++; end
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (timeout_err !== 1'b1 || note_cnt !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL tmo_en_low: err %b cnt %0d busy %b required 1/0/0", timeout_err, note_cnt, busy); end
        en = 1'b1;
        @(negedge clk);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", timeout_err); end
        rst = 1'b1;
        #1;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_rst_clear: got %b required 0", timeout_err); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_en_low();
        set_pl(2, 3'd5, 4'd14, 3'd2);
        req = 3'b100;
        repeat (6) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++; if (abort !== 3'b100) begin errors++; $display("FAIL enlow_abort: got %b required 100", abort); end
        checks++; if ({grant, snd_en, busy} !== 5'b0 || snd_note !== 4'd0) begin errors++; $display("FAIL enlow_idle: got %b note %0d required 0", {grant, snd_en, busy}, snd_note); end
        @(negedge clk);
        checks++; if (abort !== 3'b000) begin errors++; $display("FAIL enlow_pulse: got %b required 000", abort); end
        req = 3'b000; en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_play();
        int n;
        play_len = 20;
        set_pl(1, 3'd5, 4'd12, 3'd6);
        req = 3'b010;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({grant, snd_en, busy, done, abort} !== 11'b0 || {snd_oct, snd_note, snd_len} !== 10'b0) begin errors++; $display("FAIL rst_async: got %b / %h required 0", {grant, snd_en, busy, done, abort}, {snd_oct, snd_note, snd_len}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 3'b010 || snd_note !== 4'd12) begin errors++; $display("FAIL rst_regrant: grant %b note %0d required 010 note 12", grant, snd_note); end
        req = 3'b000;
        n = 0; while (done == 3'b000 && n < 200) begin @(negedge clk); n++; end
        checks++; if (done !== 3'b010) begin errors++; $display("FAIL rst_drop_plays: done %b required 010", done); end
        n = 0; while (busy && n < 100) begin @(negedge clk); n++; end
    endtask

    // Reference: all requests of a round are raised together and each drops when
    // its note completes, so service order is simply ascending source index.
    task automatic test_random();
        int n, exp_cnt;
        logic [2:0]    m;
        logic [OW-1:0] po [3];
        logic [NW-1:0] pn [3];
        logic [LW-1:0] pl [3];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        for (int r = 0; r < 12; r++) begin
            m = 3'($urandom_range(1, 7));
            play_len = $urandom_range(3, 15);
            for (int s = 0; s < 3; s++) begin
                po[s] = OW'($urandom); pn[s] = NW'($urandom); pl[s] = LW'($urandom);
                set_pl(s, po[s], pn[s], pl[s]);
            end
            req = m;
            for (int s = 0; s < 3; s++) begin
                if (m[s]) begin
                    n = 0; while (grant == 3'b000 && n < 400) begin @(negedge clk); n++; end
                    checks++; if (grant !== 3'(1 << s)) begin errors++; $display("FAIL rnd_grant r%0d: got %b required %b", r, grant, 3'(1 << s)); end
                    checks++; if ({snd_oct, snd_note, snd_len} !== {po[s], pn[s], pl[s]}) begin errors++; $display("FAIL rnd_payload r%0d: got %h required %h", r, {snd_oct, snd_note, snd_len}, {po[s], pn[s], pl[s]}); end
                    set_pl(s, ~po[s], ~pn[s], ~pl[s]);
                    n = 0; while (done == 3'b000 && n < 400) begin @(negedge clk); n++; end
                    checks++; if (done !== 3'(1 << s) || {snd_oct, snd_note, snd_len} !== {po[s], pn[s], pl[s]}) begin errors++; $display("FAIL rnd_done r%0d: done %b payload %h required %b %h", r, done, {snd_oct, snd_note, snd_len}, 3'(1 << s), {po[s], pn[s], pl[s]}); end
                    req[s] = 1'b0;
                    exp_cnt++;
                end
            end
            n = 0; while (busy && n < 100) begin @(negedge clk); n++; end
            checks++; if (note_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt r%0d: got %0d required %0d", r, note_cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single_song();
        test_priority();
        test_preempt();
        test_no_preempt();
        test_timeout();
        test_en_low();
        test_reset_mid_play();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
Shares the single Sound engine and its buzzer between three requesters: live key hits, record playback and song autoplay. Uses fixed-priority arbitration with optional preemption by live hits. The block latches the granted note payload, sequences the engine enable around its `over` flag, and inserts a silent gap between notes. It sits between the mode logic (free/study/record) and the Sound instance, and replaces ad-hoc `en | ~over` gating.

Parameters:
OCT_W, 3, octave field width (`OCTAVE_BITS`)
NOTE_W, 4, note field width (`NOTE_BITS`)
LEN_W, 3, length field width (`LENGTH_BITS`)
GAP_CYCLES, 16, silent cycles between consecutive notes (>=1)
START_TIMEOUT, 1024, max cycles waiting for engine to drop over
PREEMPT, 1, 1 = live hit aborts a record or song note in progress

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  arbiter enable; low forces idle
req  in  3  level requests: [0] live hit, [1] record, [2] song
oct_in  in  3*OCT_W  per-requester octave, packed, index i at [i*OCT_W +: OCT_W]
note_in  in  3*NOTE_W  per-requester note, packed
len_in  in  3*LEN_W  per-requester length, packed
grant  out  3  one-hot, high while a requester owns the engine
done  out  3  1-cycle pulse: granted note completed
abort  out  3  1-cycle pulse: granted note preempted or timed out
snd_en  out  1  engine enable
snd_oct  out  OCT_W  latched octave to engine
snd_note  out  NOTE_W  latched note to engine
snd_len  out  LEN_W  latched length to engine
snd_over  in  1  engine idle/finished flag (low while sounding)
busy  out  1  state != IDLE
note_cnt  out  16  completed-note counter, saturating
timeout_err  out  1  sticky: a START timeout occurred

Behaviour:
- Reset, and en low: state IDLE; grant/done/abort = 0; snd_en = 0; snd_* = 0; busy = 0; counters = 0. timeout_err is cleared by rst only (en low does not clear it). en low mid-note: snd_en drops next cycle and the holder gets an abort pulse.
- Priority: live(0) > record(1) > song(2); fixed, no round-robin.
- Requesters hold req with payload stable until done or abort. Dropping req while granted has no effect; the note plays out.
- IDLE: if any req, on the same edge:
  - latch the winner's payload into snd_*;
  - set grant;
  - set snd_en = 1;
  - go to START.
  - Latency: req sampled at edge N gives grant and snd_en visible after edge N.
- START: snd_en = 1. On snd_over == 0, go to PLAY. If the wait counter reaches START_TIMEOUT with over still high: abort pulse, set timeout_err, go to GAP.
- PLAY: snd_en = 1 until snd_over == 1. Then snd_en = 0, done pulse for the holder, note_cnt += 1 (saturates at 0xFFFF), go to GAP.
- GAP: snd_en = 0, grant = 0. Count GAP_CYCLES, then go to IDLE.
- Requests are evaluated only in IDLE. A done and a new req in the same cycle are served after the gap.
- Preemption (PREEMPT=1): req[0] high while holder is 1 or 2 in START/PLAY causes:
  - abort pulse to the holder;
  - snd_en = 0 for exactly 1 cycle;
  - grant and payload switch to live;
  - state goes to START, with no GAP.
  - A live note is never preempted.
- Payload is latched; changing oct_in/note_in/len_in during a grant never reaches the engine.
- done/abort are mutually exclusive per cycle; at most one bit is set.

Decomposition:
- `Constants.vh` holds OCTAVE/NOTE/LENGTH widths, source indices SRC_LIVE=0/SRC_REC=1/SRC_SONG=2, and state encodings.
- Sub-module `prio_pick3`: combinational 3-input fixed-priority one-hot picker plus index encode. Reused by any future arbiter.

Test Plan:
- req=3'b100 only (song, oct 4, note 5, len 2); engine model drops over 2 cycles after snd_en and raises it 20 cycles later -> grant=3'b100 at next edge; snd_note=5; done[2] pulse once; note_cnt=1; snd_en low for 16 cycles.
- req=3'b110 simultaneously -> grant=3'b010 first; song granted only after record's done + 16 gap cycles.
- Song playing in PLAY, req[0] rises with note 7 -> abort[2] pulse; snd_en low 1 cycle; grant=3'b001; snd_note=7; no gap.
- PREEMPT=0, same stimulus -> song completes with done[2]; live granted after gap.
- Engine model never drops over -> abort pulse after 1024 START cycles; timeout_err=1; timeout_err persists through en toggle; cleared by rst.
- Assert rst mid-PLAY -> all outputs 0 asynchronously; req held high -> re-granted on the first edge after rst release.
